// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: FSM state codes and register file codes.
// ZERO/ONE are hard-wired constant registers that must never be written.
`timescale 1ns/1ps
package writeback_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  localparam logic [REG_W-1:0] REG_ZERO = 4'd0;
  localparam logic [REG_W-1:0] REG_ONE  = 4'd1;
  localparam logic [REG_W-1:0] REG_R0   = 4'd2;
  localparam logic [REG_W-1:0] REG_R1   = 4'd3;
  localparam logic [REG_W-1:0] REG_R2   = 4'd4;
  localparam logic [REG_W-1:0] REG_R3   = 4'd5;

  function automatic logic is_const_reg(input logic [REG_W-1:0] code);
    return (code == REG_ZERO) || (code == REG_ONE);
  endfunction

endpackage

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU or load results to the register file, stalls on
// pending loads with a timeout, and republishes the previous commit as an ID bypass.
`timescale 1ns/1ps
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              regwrite_in,
  input  logic              memread_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready_in,
  output logic              stall_out,
  output logic              setwrite_out,
  output logic [REG_W-1:0]  sel_regwrite_out,
  output logic [DATA_W-1:0] data_out,
  output logic              fwd_valid_out,
  output logic [REG_W-1:0]  fwd_reg_out,
  output logic [DATA_W-1:0] fwd_data_out,
  output logic              err_out,
  output logic [CNT_W-1:0]  commit_count_out
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              stall_q, stall_d;
  logic              setwrite_q, setwrite_d;
  logic [REG_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [REG_W-1:0]  fwd_reg_q, fwd_reg_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  commit_q, commit_d;

  logic              wr_req;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    dest_d      = dest_q;
    err_d       = 1'b0;
    wr_req      = 1'b0;
    wr_reg      = write_reg_in;
    wr_data     = alu_result_in;
    // Bypass is a one-cycle delayed copy of the write port, commit or not.
    fwd_valid_d = setwrite_q;
    fwd_reg_d   = sel_q;
    fwd_data_d  = data_q;

    unique case (state_q)
      WB_IDLE: begin
        if (valid_in && regwrite_in) begin
          if (memread_in) begin
            state_d  = WB_WAIT;
            dest_d   = write_reg_in;
            to_cnt_d = '0;
          end else begin
            wr_req = 1'b1;
          end
        end
      end
      WB_WAIT: begin
        // Ready on the final cycle beats the timeout.
        if (mem_ready_in) begin
          state_d = WB_IDLE;
          wr_req  = 1'b1;
          wr_reg  = dest_q;
          wr_data = mem_data_in;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = WB_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase

    setwrite_d = 1'b0;
    sel_d      = sel_q;
    data_d     = data_q;
    commit_d   = commit_q;
    if (wr_req && !is_const_reg(wr_reg)) begin
      setwrite_d = 1'b1;
      sel_d      = wr_reg;
      data_d     = wr_data;
      commit_d   = commit_q + CNT_W'(1);
    end

    stall_d = (state_d == WB_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      to_cnt_q    <= '0;
      dest_q      <= '0;
      stall_q     <= 1'b0;
      setwrite_q  <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
      commit_q    <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      dest_q      <= dest_d;
      stall_q     <= stall_d;
      setwrite_q  <= setwrite_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
      err_q       <= err_d;
      commit_q    <= commit_d;
    end
  end

  assign stall_out        = stall_q;
  assign setwrite_out     = setwrite_q;
  assign sel_regwrite_out = sel_q;
  assign data_out         = data_q;
  assign fwd_valid_out    = fwd_valid_q;
  assign fwd_reg_out      = fwd_reg_q;
  assign fwd_data_out     = fwd_data_q;
  assign err_out          = err_q;
  assign commit_count_out = commit_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: hand-computed vector table, counter wrap sequence, and a
// randomized run checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, valid_in, regwrite_in, memread_in, mem_ready_in;
  logic [3:0]  write_reg_in;
  logic [15:0] alu_result_in, mem_data_in;
  logic        stall_out, setwrite_out, fwd_valid_out, err_out;
  logic [3:0]  sel_regwrite_out, fwd_reg_out;
  logic [15:0] data_out, fwd_data_out;
  logic [CW-1:0] commit_count_out;

  writeback_stage #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .regwrite_in(regwrite_in),
    .memread_in(memread_in), .write_reg_in(write_reg_in), .alu_result_in(alu_result_in),
    .mem_data_in(mem_data_in), .mem_ready_in(mem_ready_in), .stall_out(stall_out),
    .setwrite_out(setwrite_out), .sel_regwrite_out(sel_regwrite_out), .data_out(data_out),
    .fwd_valid_out(fwd_valid_out), .fwd_reg_out(fwd_reg_out), .fwd_data_out(fwd_data_out),
    .err_out(err_out), .commit_count_out(commit_count_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a load is outstanding until data arrives or TO wait
  // cycles have elapsed without data.
  bit        m_pending;
  int        m_waited;
  int        m_reg;
  bit        m_stall, m_sw, m_err, m_fv;
  int        m_sel, m_data, m_cnt, m_fr, m_fd;

  task automatic model_commit(input int r, input int d);
    if (r != REG_ZERO && r != REG_ONE) begin
      m_sw = 1; m_sel = r; m_data = d;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pending = 0; m_waited = 0; m_reg = 0;
      m_stall = 0; m_sw = 0; m_err = 0; m_fv = 0;
      m_sel = 0; m_data = 0; m_cnt = 0; m_fr = 0; m_fd = 0;
      return;
    end
    m_fv = m_sw; m_fr = m_sel; m_fd = m_data;
    m_sw = 0; m_err = 0;
    if (!m_pending) begin
      if (valid_in && regwrite_in) begin
        if (memread_in) begin
          m_pending = 1; m_waited = 0; m_reg = write_reg_in;
        end else begin
          model_commit(write_reg_in, alu_result_in);
        end
      end
    end else if (mem_ready_in) begin
      model_commit(m_reg, mem_data_in);
      m_pending = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        m_pending = 0; m_err = 1;
      end
    end
    m_stall = m_pending;
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".stall"},    32'(stall_out),        32'(m_stall));
    chk({tag, ".setwrite"}, 32'(setwrite_out),     32'(m_sw));
    chk({tag, ".sel"},      32'(sel_regwrite_out), 32'(m_sel));
    chk({tag, ".data"},     32'(data_out),         32'(m_data));
    chk({tag, ".err"},      32'(err_out),          32'(m_err));
    chk({tag, ".count"},    32'(commit_count_out), 32'(m_cnt));
    chk({tag, ".fwd_valid"},32'(fwd_valid_out),    32'(m_fv));
    chk({tag, ".fwd_reg"},  32'(fwd_reg_out),      32'(m_fr));
    chk({tag, ".fwd_data"}, 32'(fwd_data_out),     32'(m_fd));
  endtask

  // Drive inputs away from the edge, clock once, then sample 1ns after the edge.
  task automatic step(input logic r, input logic v, input logic rw, input logic mr,
                      input logic [3:0] rg, input logic [15:0] alu, input logic [15:0] mem,
                      input logic rdy);
    @(negedge clk);
    rst = r; valid_in = v; regwrite_in = rw; memread_in = mr; write_reg_in = rg;
    alu_result_in = alu; mem_data_in = mem; mem_ready_in = rdy;
    @(posedge clk);
    #1;
    model_step();
  endtask

  typedef struct {
    logic r, v, rw, mr;
    logic [3:0] rg;
    logic [15:0] alu, mem;
    logic rdy;
    logic e_stall, e_sw;
    logic [3:0] e_sel;
    logic [15:0] e_data;
    logic e_err;
    logic [3:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic rw, logic mr, logic [3:0] rg,
                              logic [15:0] alu, logic [15:0] mem, logic rdy,
                              logic es, logic ew, logic [3:0] esel, logic [15:0] ed,
                              logic ee, logic [3:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.rw = rw; t.mr = mr; t.rg = rg; t.alu = alu; t.mem = mem; t.rdy = rdy;
    t.e_stall = es; t.e_sw = ew; t.e_sel = esel; t.e_data = ed; t.e_err = ee; t.e_cnt = ec;
    return t;
  endfunction

  vec_t tbl[32];

  initial begin
    rst = 1; valid_in = 0; regwrite_in = 0; memread_in = 0; write_reg_in = 0;
    alu_result_in = 0; mem_data_in = 0; mem_ready_in = 0;

    //            rst v rw mr reg       alu      mem      rdy  stall sw sel     data     err cnt
    tbl[0]  = mk(1, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, 4'd0,  16'h0,    0, 4'd0);
    tbl[1]  = mk(1, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, 4'd0,  16'h0,    0, 4'd0);
    tbl[2]  = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, 4'd0,  16'h0,    0, 4'd0);
    tbl[3]  = mk(0, 1, 1, 0, REG_R1,  16'h1234, 16'h0,    0,   0, 1, REG_R1, 16'h1234, 0, 4'd1);
    tbl[4]  = mk(0, 1, 1, 0, REG_R2,  16'hABCD, 16'h0,    0,   0, 1, REG_R2, 16'hABCD, 0, 4'd2);
    tbl[5]  = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, REG_R2, 16'hABCD, 0, 4'd2);
    tbl[6]  = mk(0, 1, 1, 1, REG_R3,  16'h5555, 16'h0,    0,   1, 0, REG_R2, 16'hABCD, 0, 4'd2);
    tbl[7]  = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R2, 16'hABCD, 0, 4'd2);
    tbl[8]  = mk(0, 1, 1, 0, REG_R1,  16'h6666, 16'h0,    0,   1, 0, REG_R2, 16'hABCD, 0, 4'd2);
    tbl[9]  = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'hBEEF, 1,   0, 1, REG_R3, 16'hBEEF, 0, 4'd3);
    tbl[10] = mk(0, 1, 1, 0, REG_R0,  16'h0042, 16'h0,    0,   0, 1, REG_R0, 16'h0042, 0, 4'd4);
    tbl[11] = mk(0, 1, 1, 1, REG_R1,  16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[12] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[13] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[14] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[15] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, REG_R0, 16'h0042, 1, 4'd4);
    tbl[16] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[17] = mk(0, 1, 1, 1, REG_R2,  16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[18] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[19] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[20] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R0, 16'h0042, 0, 4'd4);
    tbl[21] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h7777, 1,   0, 1, REG_R2, 16'h7777, 0, 4'd5);
    tbl[22] = mk(0, 1, 1, 0, REG_ZERO,16'hFFFF, 16'h0,    0,   0, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[23] = mk(0, 1, 1, 0, REG_ONE, 16'h1111, 16'h0,    0,   0, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[24] = mk(0, 1, 0, 1, REG_R1,  16'h3333, 16'h0,    0,   0, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[25] = mk(0, 1, 1, 1, REG_ONE, 16'h0,    16'h0,    0,   1, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[26] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[27] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h2222, 1,   0, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[28] = mk(0, 1, 1, 1, REG_R3,  16'h0,    16'h0,    0,   1, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[29] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   1, 0, REG_R2, 16'h7777, 0, 4'd5);
    tbl[30] = mk(1, 0, 0, 0, 4'd0,    16'h0,    16'h9999, 1,   0, 0, 4'd0,  16'h0,    0, 4'd0);
    tbl[31] = mk(0, 0, 0, 0, 4'd0,    16'h0,    16'h0,    0,   0, 0, 4'd0,  16'h0,    0, 4'd0);

    for (int i = 0; i < 32; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].r, tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].rg, tbl[i].alu, tbl[i].mem, tbl[i].rdy);
      chk({tag, ".stall"},    32'(stall_out),        32'(tbl[i].e_stall));
      chk({tag, ".setwrite"}, 32'(setwrite_out),     32'(tbl[i].e_sw));
      chk({tag, ".sel"},      32'(sel_regwrite_out), 32'(tbl[i].e_sel));
      chk({tag, ".data"},     32'(data_out),         32'(tbl[i].e_data));
      chk({tag, ".err"},      32'(err_out),          32'(tbl[i].e_err));
      chk({tag, ".count"},    32'(commit_count_out), 32'(tbl[i].e_cnt));
      model_compare({tag, ".model"});
    end

    // Bypass lags the commit of vec4 (R2=ABCD) by one cycle; checked right after vec5.
    // Count wrap: 16 back-to-back commits from a zero count return to zero.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0, REG_R0, 16'(i + 16'h100), 16'h0, 0);
      chk($sformatf("wrap%0d.count", i), 32'(commit_count_out), 32'((i + 1) % 16));
      chk($sformatf("wrap%0d.data", i), 32'(data_out), 32'(i + 16'h100));
      if (i > 0) chk($sformatf("wrap%0d.fwd_data", i), 32'(fwd_data_out), 32'(i - 1 + 16'h100));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic r, v, rw, mr, rdy;
      logic [3:0] rg;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 9) < 7);
      rw  = ($urandom_range(0, 9) < 8);
      mr  = ($urandom_range(0, 9) < 4);
      rdy = ($urandom_range(0, 9) < 3);
      rg  = 4'($urandom_range(0, 15));
      step(r, v, rw, mr, rg, 16'($urandom), 16'($urandom), rdy);
      model_compare($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
